// File: rtl/timer_pkg.sv
// Shared field positions and clock-select decode for the 8-bit timer.
package timer_pkg;

  localparam int TCR_LOAD   = 7;
  localparam int TCR_DIR    = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  typedef enum logic [1:0] {
    CKS_DIV2  = 2'b00,
    CKS_DIV4  = 2'b01,
    CKS_DIV8  = 2'b10,
    CKS_DIV16 = 2'b11
  } cks_e;

  function automatic logic [4:0] cks_ratio(input cks_e cks);
    logic [4:0] ratio;
    case (cks)
      CKS_DIV2:  ratio = 5'd2;
      CKS_DIV4:  ratio = 5'd4;
      CKS_DIV8:  ratio = 5'd8;
      default:   ratio = 5'd16;
    endcase
    return ratio;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: divides PCLK by the cks-selected ratio and emits a one-cycle tick.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRESC_W = 4
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic i_en,
  input  logic i_load,
  input  cks_e i_cks,
  output logic o_tick
);

  logic [PRESC_W-1:0] r_cnt;
  cks_e               r_cks_q;
  logic [PRESC_W-1:0] w_tc;
  logic               w_cks_chg;
  logic               w_at_tc;

  assign w_tc      = PRESC_W'(cks_ratio(i_cks) - 5'd1);
  assign w_cks_chg = (i_cks != r_cks_q);
  assign w_at_tc   = (r_cnt == w_tc);

  // A ratio change restarts the period, so the tick of that cycle is dropped.
  assign o_tick = i_en && !i_load && !w_cks_chg && w_at_tc;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt   <= '0;
      r_cks_q <= CKS_DIV2;
    end else begin
      r_cks_q <= i_cks;
      if (i_load || w_cks_chg) begin
        r_cnt <= '0;
      end else if (i_en) begin
        r_cnt <= w_at_tc ? '0 : r_cnt + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/timer_counter_core.sv
// Counting engine of the APB 8-bit timer: live count, sticky wrap flags, irq.
module timer_counter_core
  import timer_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 4
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [7:0]       tcr,
  input  logic [CNT_W-1:0] tdr,
  input  logic [1:0]       tsr_clr,
  output logic [CNT_W-1:0] tcnt,
  output logic             ovf_flag,
  output logic             udf_flag,
  output logic             irq,
  output logic             tick
);

  logic             w_load;
  logic             w_dir;
  logic             w_en;
  cks_e             w_cks;
  logic             w_tick;
  logic             w_ovf_set;
  logic             w_udf_set;
  logic             w_unused_tcr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_udf;
  logic             r_irq;

  assign w_load       = tcr[TCR_LOAD];
  assign w_dir        = tcr[TCR_DIR];
  assign w_en         = tcr[TCR_EN];
  assign w_cks        = cks_e'(tcr[TCR_CKS_HI:TCR_CKS_LO]);
  assign w_unused_tcr = ^{tcr[6], tcr[3:2]};

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .i_en    (w_en),
    .i_load  (w_load),
    .i_cks   (w_cks),
    .o_tick  (w_tick)
  );

  assign w_ovf_set = !w_load && w_tick && !w_dir && (r_cnt == '1);
  assign w_udf_set = !w_load && w_tick &&  w_dir && (r_cnt == '0);

  // Flags: a set in the same cycle as its clear pulse wins.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_load) begin
        r_cnt <= tdr;
      end else if (w_tick) begin
        r_cnt <= w_dir ? r_cnt - CNT_W'(1) : r_cnt + CNT_W'(1);
      end
      r_ovf <= w_ovf_set || (r_ovf && !tsr_clr[TSR_OVF]);
      r_udf <= w_udf_set || (r_udf && !tsr_clr[TSR_UDF]);
      r_irq <= r_ovf || r_udf;
    end
  end

  assign tcnt     = r_cnt;
  assign ovf_flag = r_ovf;
  assign udf_flag = r_udf;
  assign irq      = r_irq;
  assign tick     = w_tick;

endmodule

// File: tb/tb_timer_counter_core.sv
// Directed bench for timer_counter_core; expectations are queued per cycle and checked at negedge.
module tb_timer_counter_core;

  logic       PCLK;
  logic       PRESETn;
  logic [7:0] tcr;
  logic [7:0] tdr;
  logic [1:0] tsr_clr;
  logic [7:0] tcnt;
  logic       ovf_flag;
  logic       udf_flag;
  logic       irq;
  logic       tick;

  timer_counter_core dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .tcr      (tcr),
    .tdr      (tdr),
    .tsr_clr  (tsr_clr),
    .tcnt     (tcnt),
    .ovf_flag (ovf_flag),
    .udf_flag (udf_flag),
    .irq      (irq),
    .tick     (tick)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Observed word layout: {tick, tcnt[7:0], ovf, udf, irq}
  localparam logic [11:0] M_TICK = 12'h800;
  localparam logic [11:0] M_CNT  = 12'h7F8;
  localparam logic [11:0] M_OVF  = 12'h004;
  localparam logic [11:0] M_UDF  = 12'h002;
  localparam logic [11:0] M_IRQ  = 12'h001;
  localparam logic [11:0] M_ALL  = 12'hFFF;

  typedef struct {
    int          cyc;
    string       tag;
    logic [11:0] mask;
    logic [11:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  int   cyc_n = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [11:0] w_obs;

  assign w_obs = {tick, tcnt, ovf_flag, udf_flag, irq};

  always @(posedge PCLK) cyc_n = cyc_n + 1;

  function automatic logic [11:0] ev(input logic tk, input logic [7:0] c,
                                     input logic o, input logic u, input logic i);
    return {tk, c, o, u, i};
  endfunction

  task automatic push(input int k, input string tag, input logic [11:0] mask,
                      input logic [11:0] exp);
    sb_t e;
    int  pos;
    e.cyc  = cyc_n + k;
    e.tag  = tag;
    e.mask = mask;
    e.exp  = exp;
    pos = sb_q.size();
    while (pos > 0 && sb_q[pos-1].cyc > e.cyc) pos--;
    sb_q.insert(pos, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  always @(negedge PCLK) begin
    sb_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_n) begin
      e = sb_q.pop_front();
      n_assert++;
      assert (((w_obs & e.mask) === (e.exp & e.mask)) && (e.cyc == cyc_n)) else begin
        n_fail++;
        $error("FAIL %s cycle=%0d/%0d observed=%h expected=%h mask=%h",
               e.tag, cyc_n, e.cyc, w_obs & e.mask, e.exp & e.mask, e.mask);
      end
    end
  end

  initial begin
    int waited;
    PRESETn = 1'b0;
    tcr     = 8'h00;
    tdr     = 8'h00;
    tsr_clr = 2'b00;
    step(2);
    push(0, "rst_state", M_ALL, 12'h000);
    step(1);

    // Load FC, then count up at /2 through the FF -> 00 wrap
    PRESETn = 1'b1;
    tcr = 8'h80;
    tdr = 8'hFC;
    push(0, "rst_release", M_ALL, 12'h000);
    step(1);
    tcr = 8'h10;
    push(0, "up_load",      M_CNT | M_TICK, ev(1'b0, 8'hFC, 1'b0, 1'b0, 1'b0));
    push(1, "up_tick1",     M_CNT | M_TICK, ev(1'b1, 8'hFC, 1'b0, 1'b0, 1'b0));
    push(2, "up_fd",        M_CNT,          ev(1'b0, 8'hFD, 1'b0, 1'b0, 1'b0));
    push(4, "up_fe",        M_CNT,          ev(1'b0, 8'hFE, 1'b0, 1'b0, 1'b0));
    push(6, "up_ff",        M_CNT | M_OVF | M_UDF, ev(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0));
    push(7, "up_wrap_tick", M_ALL,          ev(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0));
    push(8, "up_ovf",       M_ALL,          ev(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    push(9, "up_irq",       M_CNT | M_OVF | M_UDF | M_IRQ, ev(1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
    step(9);

    // Load 01 (clearing ovf), then count down at /16 through 00 -> FF
    tcr = 8'h80;
    tdr = 8'h01;
    tsr_clr = 2'b01;
    step(1);
    tcr = 8'h33;
    tsr_clr = 2'b00;
    push(0,  "dn_load",    M_CNT | M_OVF | M_IRQ | M_TICK, ev(1'b0, 8'h01, 1'b0, 1'b0, 1'b1));
    push(1,  "irq_drop",   M_OVF | M_UDF | M_IRQ, 12'h000);
    push(15, "dn_no_tick", M_TICK | M_CNT, ev(1'b0, 8'h01, 1'b0, 1'b0, 1'b0));
    push(16, "dn_tick1",   M_TICK | M_CNT, ev(1'b1, 8'h01, 1'b0, 1'b0, 1'b0));
    push(17, "dn_00",      M_ALL,          ev(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
    push(32, "dn_tick2",   M_TICK | M_CNT, ev(1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
    push(33, "dn_udf",     M_ALL,          ev(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0));
    push(34, "dn_irq",     M_CNT | M_OVF | M_UDF | M_IRQ, ev(1'b0, 8'hFF, 1'b0, 1'b1, 1'b1));
    step(34);

    // Direction flip keeps the prescaler phase; wrap up to set ovf as well
    tcr = 8'h13;
    push(14, "up16_tick", M_ALL, ev(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1));
    push(15, "up16_ovf",  M_ALL, ev(1'b0, 8'h00, 1'b1, 1'b1, 1'b1));
    step(15);
    tsr_clr = 2'b01;
    push(1, "clr_ovf", M_CNT | M_OVF | M_UDF | M_IRQ, ev(1'b0, 8'h00, 1'b0, 1'b1, 1'b1));
    step(1);
    tsr_clr = 2'b00;
    tcr = 8'h80;
    tdr = 8'hFF;
    step(1);
    tcr = 8'h10;
    push(0, "reload_ff", M_CNT | M_OVF | M_UDF, ev(1'b0, 8'hFF, 1'b0, 1'b1, 1'b0));
    step(1);
    tsr_clr = 2'b01;
    push(0, "wrap_clr_tick", M_ALL, ev(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1));
    step(1);
    tsr_clr = 2'b10;
    push(0, "set_wins", M_CNT | M_OVF | M_UDF, ev(1'b0, 8'h00, 1'b1, 1'b1, 1'b0));
    step(1);
    tsr_clr = 2'b11;
    push(0, "clr_udf", M_CNT | M_OVF | M_UDF, ev(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    step(1);
    tsr_clr = 2'b00;
    push(0, "clr_both", M_CNT | M_OVF | M_UDF | M_IRQ, ev(1'b0, 8'h01, 1'b0, 1'b0, 1'b1));
    step(1);

    // Switch to /8 mid-period, then back to /2 mid-period
    tcr = 8'h12;
    push(0, "cks_chg_sup", M_TICK | M_CNT | M_IRQ, ev(1'b0, 8'h01, 1'b0, 1'b0, 1'b0));
    push(1, "div8_hold",   M_TICK | M_CNT, ev(1'b0, 8'h01, 1'b0, 1'b0, 1'b0));
    push(7, "div8_pre",    M_TICK | M_CNT, ev(1'b0, 8'h01, 1'b0, 1'b0, 1'b0));
    push(8, "div8_tick",   M_TICK | M_CNT, ev(1'b1, 8'h01, 1'b0, 1'b0, 1'b0));
    push(9, "div8_cnt",    M_TICK | M_CNT, ev(1'b0, 8'h02, 1'b0, 1'b0, 1'b0));
    step(12);
    tcr = 8'h10;
    push(0, "cks_mid_clr", M_TICK | M_CNT, ev(1'b0, 8'h02, 1'b0, 1'b0, 1'b0));
    push(1, "div2_pre",    M_TICK | M_CNT, ev(1'b0, 8'h02, 1'b0, 1'b0, 1'b0));
    push(2, "div2_tick",   M_TICK | M_CNT, ev(1'b1, 8'h02, 1'b0, 1'b0, 1'b0));
    push(3, "div2_cnt",    M_TICK | M_CNT, ev(1'b0, 8'h03, 1'b0, 1'b0, 1'b0));
    step(4);

    // Drop enable on a tick cycle; the held phase must tick on resume
    tcr = 8'h00;
    for (int k = 0; k < 10; k++)
      push(k, "en_hold", M_TICK | M_CNT, ev(1'b0, 8'h03, 1'b0, 1'b0, 1'b0));
    step(10);
    tcr = 8'h10;
    push(0, "en_resume_tick", M_TICK | M_CNT, ev(1'b1, 8'h03, 1'b0, 1'b0, 1'b0));
    push(1, "en_resume_cnt",  M_TICK | M_CNT, ev(1'b0, 8'h04, 1'b0, 1'b0, 1'b0));
    step(1);

    // Level-held load with enable set
    tcr = 8'h90;
    tdr = 8'h5A;
    push(0, "load_first", M_TICK | M_CNT, ev(1'b0, 8'h04, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= 20; k++)
      push(k, "load_hold", M_ALL, ev(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0));
    step(20);
    tcr = 8'h10;
    push(1, "load_rel_tick", M_TICK | M_CNT, ev(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0));
    push(2, "load_rel_cnt",  M_TICK | M_CNT, ev(1'b0, 8'h5B, 1'b0, 1'b0, 1'b0));
    step(2);

    // Set ovf, then reset asynchronously mid-cycle
    tcr = 8'h80;
    tdr = 8'hFF;
    step(1);
    tcr = 8'h10;
    push(2, "pre_rst_ovf", M_CNT | M_OVF | M_UDF, ev(1'b0, 8'h00, 1'b1, 1'b0, 1'b0));
    push(3, "pre_rst_irq", M_OVF | M_IRQ, ev(1'b0, 8'h00, 1'b1, 1'b0, 1'b1));
    step(4);
    #2;
    PRESETn = 1'b0;
    tcr = 8'h00;
    push(0, "async_rst", M_ALL, 12'h000);
    push(1, "rst_hold",  M_ALL, 12'h000);
    step(3);
    PRESETn = 1'b1;
    for (int k = 0; k < 5; k++)
      push(k, "wait_en", M_ALL, 12'h000);
    step(5);
    tcr = 8'h10;
    push(0, "en_after_rst", M_ALL, 12'h000);
    push(1, "first_tick",   M_ALL, ev(1'b1, 8'h00, 1'b0, 1'b0, 1'b0));
    push(2, "first_cnt",    M_ALL, ev(1'b0, 8'h01, 1'b0, 1'b0, 1'b0));

    waited = 0;
    while (sb_q.size() > 0 && waited < 40) begin
      step(1);
      waited++;
    end
    n_assert++;
    assert (sb_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain pending=%0d required=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
